uart_tx_ctrl: RTL and testbench

Transmit-side controller for the UART. It pops bytes from the downstream FIFO and serialises each into a frame on `tx_o`: start bit, 8 data bits, optional even parity, then a programmable stop period. The frame format comes from the CTRL and UART_BIT_LENGTH register fields. It also raises the TX_STARTED and TX_DONE interrupt events and feeds the `tx_status` bit of STATS.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_bit_timer.sv | 42 ++++
 rtl/uart_tx_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART types and constants.
//   stop_bit_mode_t   : CTRL.stop_bit_mode encoding (stop period length)
//   uart_tx_state_t   : TX controller FSM states
//   UART_MIN_BIT_LENGTH : smallest usable clocks-per-bit value
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    HALF_PERIOD          = 2'd0,
    FULL_PERIOD          = 2'd1,
    ONE_AND_HALF_PERIODS = 2'd2,
    TWO_PERIODS          = 2'd3
  } stop_bit_mode_t;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_FETCH  = 3'd1,
    TX_START  = 3'd2,
    TX_DATA   = 3'd3,
    TX_PARITY = 3'd4,
    TX_STOP   = 3'd5
  } uart_tx_state_t;

  localparam int unsigned UART_MIN_BIT_LENGTH = 32'd2;

endpackage

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Down-counting period timer shared by the UART TX and RX controllers.
// A load of period P makes tc_o rise exactly P clocks later (P >= 1).
//   clk_i    in  clock
//   rstn_i   in  asynchronous active-low reset
//   clr_i    in  synchronous clear (abort)
//   load_i   in  start a new period
//   period_i in  period length in clocks
//   tc_o     out terminal count (last clock of the period)
// -----------------------------------------------------------------------------
module uart_bit_timer #(
  parameter int WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] period_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] r_count;

  // Remaining-clocks counter; stalls at zero until the next load.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= period_i - WIDTH'(1);
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign tc_o = (r_count == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit controller: pops bytes from the downstream FIFO and sends
// start bit, DATA_WIDTH data bits, optional even parity and a programmable
// stop period on tx_o. Frame format is snapshotted per frame in FETCH.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   bit_length_i         clocks per bit (clamped to UART_MIN_BIT_LENGTH)
//   msb_first_i          data bit order
//   send_parity_i        append even parity bit
//   stop_bit_mode_i      stop period length
//   hw_flow_ctrl_en_i    enable CTS gating
//   cts_n_i              clear-to-send, active-low, synchronised
//   flush_i              synchronous abort back to IDLE
//   fifo_empty_i         downstream FIFO empty
//   fifo_rd_o            FIFO pop strobe (data valid the following cycle)
//   fifo_data_i          FIFO read data
//   tx_o                 serial line (flop output)
//   busy_o               state is not IDLE
//   tx_started_o         pulse on first START clock
//   tx_done_o            pulse on last STOP clock
//
// Build option: UART_HW_FLOW_CTRL_EN enables CTS gating; without it CTS
// inputs are ignored and the controller always may start.
// -----------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BITLEN_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [BITLEN_WIDTH-1:0] bit_length_i,
  input  logic                    msb_first_i,
  input  logic                    send_parity_i,
  input  stop_bit_mode_t          stop_bit_mode_i,
  input  logic                    hw_flow_ctrl_en_i,
  input  logic                    cts_n_i,
  input  logic                    flush_i,
  input  logic                    fifo_empty_i,
  output logic                    fifo_rd_o,
  input  logic [DATA_WIDTH-1:0]   fifo_data_i,
  output logic                    tx_o,
  output logic                    busy_o,
  output logic                    tx_started_o,
  output logic                    tx_done_o
);

  localparam int CW   = BITLEN_WIDTH + 2;
  localparam int IDXW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_tx_state_t          r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_shift, w_shift_nxt;
  logic [IDXW-1:0]         r_bit_idx, w_idx_nxt;
  logic                    r_parity, w_parity_nxt;
  logic                    r_msb_first, w_msb_nxt;
  logic                    r_send_parity;
  stop_bit_mode_t          r_stop_mode;
  logic [BITLEN_WIDTH-1:0] r_bit_len;
  logic                    r_tx, w_tx_nxt;
  logic                    r_tx_started;

  logic [BITLEN_WIDTH-1:0] w_eff_len;
  logic [CW-1:0]           w_len_ext, w_stop_len, w_tmr_period;
  logic                    w_tmr_load, w_tc;
  logic                    w_fifo_rd, w_tx_done, w_cts_ok, w_data_bit;

`ifdef UART_HW_FLOW_CTRL_EN
  assign w_cts_ok = !hw_flow_ctrl_en_i || !cts_n_i;
`else
  logic w_unused_cts;
  assign w_cts_ok     = 1'b1;
  assign w_unused_cts = cts_n_i ^ hw_flow_ctrl_en_i;
`endif

  assign w_eff_len = (bit_length_i < BITLEN_WIDTH'(UART_MIN_BIT_LENGTH))
                   ? BITLEN_WIDTH'(UART_MIN_BIT_LENGTH) : bit_length_i;
  assign w_len_ext  = {2'b00, r_bit_len};
  // Bit currently on the line; the shift register always presents it at one end.
  assign w_data_bit = r_msb_first ? r_shift[DATA_WIDTH-1] : r_shift[0];

  // Stop period from the snapshotted mode; two extra bits keep 2L exact.
  always_comb begin
    w_stop_len = w_len_ext;
    case (r_stop_mode)
      HALF_PERIOD:          w_stop_len = w_len_ext >> 1;
      FULL_PERIOD:          w_stop_len = w_len_ext;
      ONE_AND_HALF_PERIODS: w_stop_len = w_len_ext + (w_len_ext >> 1);
      TWO_PERIODS:          w_stop_len = w_len_ext << 1;
      default:              w_stop_len = w_len_ext;
    endcase
  end

  uart_bit_timer #(.WIDTH(CW)) u_bit_timer (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .clr_i    (flush_i),
    .load_i   (w_tmr_load),
    .period_i (w_tmr_period),
    .tc_o     (w_tc)
  );

  // Next-state, datapath next values and strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_fifo_rd    = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_period = w_len_ext;
    w_tx_done    = 1'b0;
    w_shift_nxt  = r_shift;
    w_idx_nxt    = r_bit_idx;
    w_parity_nxt = r_parity;
    w_msb_nxt    = r_msb_first;
    case (r_state)
      TX_IDLE: begin
        if (!fifo_empty_i && w_cts_ok) begin
          w_fifo_rd   = 1'b1;
          w_state_nxt = TX_FETCH;
        end else begin
          w_state_nxt = TX_IDLE;
        end
      end
      TX_FETCH: begin
        // Snapshot regs are not valid yet, so time START from the live length.
        w_state_nxt  = TX_START;
        w_tmr_load   = 1'b1;
        w_tmr_period = {2'b00, w_eff_len};
        w_shift_nxt  = fifo_data_i;
        w_idx_nxt    = '0;
        w_parity_nxt = 1'b0;
        w_msb_nxt    = msb_first_i;
      end
      TX_START: begin
        if (w_tc) begin
          w_state_nxt = TX_DATA;
          w_tmr_load  = 1'b1;
        end else begin
          w_state_nxt = TX_START;
        end
      end
      TX_DATA: begin
        if (w_tc) begin
          w_tmr_load   = 1'b1;
          w_parity_nxt = r_parity ^ w_data_bit;
          w_shift_nxt  = r_msb_first ? {r_shift[DATA_WIDTH-2:0], 1'b0}
                                     : {1'b0, r_shift[DATA_WIDTH-1:1]};
          if (r_bit_idx == IDXW'(DATA_WIDTH - 1)) begin
            w_state_nxt  = r_send_parity ? TX_PARITY : TX_STOP;
            w_tmr_period = r_send_parity ? w_len_ext : w_stop_len;
          end else begin
            w_idx_nxt = r_bit_idx + IDXW'(1);
          end
        end else begin
          w_state_nxt = TX_DATA;
        end
      end
      TX_PARITY: begin
        if (w_tc) begin
          w_state_nxt  = TX_STOP;
          w_tmr_load   = 1'b1;
          w_tmr_period = w_stop_len;
        end else begin
          w_state_nxt = TX_PARITY;
        end
      end
      TX_STOP: begin
        if (w_tc) begin
          w_state_nxt = TX_IDLE;
          w_tx_done   = 1'b1;
        end else begin
          w_state_nxt = TX_STOP;
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
    if (flush_i) begin
      w_state_nxt = TX_IDLE;
      w_fifo_rd   = 1'b0;
      w_tmr_load  = 1'b0;
      w_tx_done   = 1'b0;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // Line level for the coming cycle, so tx_o itself comes straight from a flop.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      TX_START:  w_tx_nxt = 1'b0;
      TX_DATA:   w_tx_nxt = w_msb_nxt ? w_shift_nxt[DATA_WIDTH-1] : w_shift_nxt[0];
      TX_PARITY: w_tx_nxt = w_parity_nxt;
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  // FSM state, datapath and registered line/started outputs.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= TX_IDLE;
      r_shift      <= '0;
      r_bit_idx    <= '0;
      r_parity     <= 1'b0;
      r_msb_first  <= 1'b0;
      r_tx         <= 1'b1;
      r_tx_started <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_idx    <= w_idx_nxt;
      r_parity     <= w_parity_nxt;
      r_msb_first  <= w_msb_nxt;
      r_tx         <= w_tx_nxt;
      r_tx_started <= (r_state == TX_FETCH) && !flush_i;
    end
  end

  // Per-frame format snapshot; register writes mid-frame apply to the next frame.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_send_parity <= 1'b0;
      r_stop_mode   <= FULL_PERIOD;
      r_bit_len     <= BITLEN_WIDTH'(UART_MIN_BIT_LENGTH);
    end else if (r_state == TX_FETCH) begin
      r_send_parity <= send_parity_i;
      r_stop_mode   <= stop_bit_mode_i;
      r_bit_len     <= w_eff_len;
    end else begin
      r_send_parity <= r_send_parity;
      r_stop_mode   <= r_stop_mode;
      r_bit_len     <= r_bit_len;
    end
  end

  assign tx_o         = r_tx;
  assign busy_o       = (r_state != TX_IDLE);
  assign tx_started_o = r_tx_started;
  assign tx_done_o    = w_tx_done;
  assign fifo_rd_o    = w_fifo_rd;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  logic           clk = 1'b0;
  logic           rstn, msb, par, hw, cts_n, flush;
  logic [31:0]    bitlen;
  stop_bit_mode_t mode;
  logic           fifo_empty, fifo_rd, tx, busy, started, done;
  logic [7:0]     fifo_data = 8'h00;

  logic [7:0] fmem [0:63];
  int pushed = 0;
  int popped = 0;
  bit exp_q[$];
  int len_q[$];
  int errors = 0;
  int checks = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8), .BITLEN_WIDTH(32)) dut (
    .clk_i(clk), .rstn_i(rstn), .bit_length_i(bitlen), .msb_first_i(msb),
    .send_parity_i(par), .stop_bit_mode_i(mode), .hw_flow_ctrl_en_i(hw),
    .cts_n_i(cts_n), .flush_i(flush), .fifo_empty_i(fifo_empty),
    .fifo_rd_o(fifo_rd), .fifo_data_i(fifo_data), .tx_o(tx), .busy_o(busy),
    .tx_started_o(started), .tx_done_o(done)
  );

  always #5 clk = ~clk;

  // FIFO model: data valid the cycle after the pop strobe.
  assign fifo_empty = (pushed == popped);
  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= fmem[popped[5:0]];
      popped    <= popped + 1;
    end
  end

  // Queue a byte and push its expected per-clock line levels to the scoreboard.
  task automatic push_byte(input logic [7:0] b);
    int lc, stop_len, n;
    bit p, d;
    lc = (bitlen < 32'd2) ? 2 : int'(bitlen);
    n = 0; p = 1'b0;
    repeat (lc) exp_q.push_back(1'b0);
    n += lc;
    for (int i = 0; i < 8; i++) begin
      d = msb ? b[7-i] : b[i];
      p ^= d;
      repeat (lc) exp_q.push_back(d);
      n += lc;
    end
    if (par) begin
      repeat (lc) exp_q.push_back(p);
      n += lc;
    end
    case (mode)
      HALF_PERIOD:          stop_len = lc / 2;
      FULL_PERIOD:          stop_len = lc;
      ONE_AND_HALF_PERIODS: stop_len = lc + lc / 2;
      default:              stop_len = 2 * lc;
    endcase
    repeat (stop_len) exp_q.push_back(1'b1);
    n += stop_len;
    len_q.push_back(n);
    fmem[pushed[5:0]] = b;
    pushed++;
  endtask

  task automatic wait_started(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (started === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (tx !== 1'b1)      begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (started !== 1'b0) begin errors++; $display("FAIL reset_started: got %b want 0", started); end
    if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", fifo_rd); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lsb_frame();
    bit ok, e;
    int n;
    bitlen = 32'd4; msb = 1'b0; par = 1'b0; mode = FULL_PERIOD;
    push_byte(8'hA5);
    wait_started(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL lsb_start: no tx_started_o within 300 clocks");
      exp_q.delete(); len_q.delete();
    end else begin
      n = len_q.pop_front();
      for (int i = 0; i < n; i++) begin
        e = exp_q.pop_front();
        checks += 2;
        if (tx !== e) begin errors++; $display("FAIL lsb_tx[%0d]: got %b want %b", i, tx, e); end
        if (done !== (i == n - 1)) begin errors++; $display("FAIL lsb_done[%0d]: got %b want %b", i, done, (i == n - 1)); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_msb_parity();
    bit ok, e;
    int n;
    bitlen = 32'd4; msb = 1'b1; par = 1'b1; mode = FULL_PERIOD;
    push_byte(8'h0F);
    wait_started(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL msbpar_start: no tx_started_o within 300 clocks");
      exp_q.delete(); len_q.delete();
    end else begin
      n = len_q.pop_front();
      for (int i = 0; i < n; i++) begin
        e = exp_q.pop_front();
        checks += 2;
        if (tx !== e) begin errors++; $display("FAIL msbpar_tx[%0d]: got %b want %b", i, tx, e); end
        if (done !== (i == n - 1)) begin errors++; $display("FAIL msbpar_done[%0d]: got %b want %b", i, done, (i == n - 1)); end
        @(negedge clk);
      end
    end
    msb = 1'b0; par = 1'b0;
  endtask

  task automatic test_stop_sweep();
    bit ok, e;
    int n;
    for (int m = 0; m < 4; m++) begin
      bitlen = 32'd5; mode = stop_bit_mode_t'(m);
      push_byte(8'h5A);
      wait_started(ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL stop%0d_start: no tx_started_o within 300 clocks", m);
        exp_q.delete(); len_q.delete();
      end else begin
        n = len_q.pop_front();
        for (int i = 0; i < n; i++) begin
          e = exp_q.pop_front();
          checks += 2;
          if (tx !== e) begin errors++; $display("FAIL stop%0d_tx[%0d]: got %b want %b", m, i, tx, e); end
          if (done !== (i == n - 1)) begin errors++; $display("FAIL stop%0d_done[%0d]: got %b want %b", m, i, done, (i == n - 1)); end
          @(negedge clk);
        end
      end
    end
    mode = FULL_PERIOD;
  endtask

  task automatic test_flow_ctrl();
    bit ok, e, saw_rd;
    int n;
    bitlen = 32'd4; hw = 1'b1; cts_n = 1'b1;
    push_byte(8'h55);
`ifdef UART_HW_FLOW_CTRL_EN
    saw_rd = 1'b0;
    repeat (100) begin
      saw_rd |= (fifo_rd === 1'b1);
      @(negedge clk);
    end
    checks++;
    if (saw_rd) begin errors++; $display("FAIL flow_blocked: fifo_rd_o seen %b want 0 while CTS high", saw_rd); end
    cts_n = 1'b0;
    #1;
    checks++;
    if (fifo_rd !== 1'b1) begin errors++; $display("FAIL flow_release_rd: got %b want 1", fifo_rd); end
`endif
    wait_started(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL flow_start: no tx_started_o within 300 clocks");
      exp_q.delete(); len_q.delete();
    end else begin
      n = len_q.pop_front();
      for (int i = 0; i < n; i++) begin
        if (i == 10) cts_n = 1'b1;
        e = exp_q.pop_front();
        checks += 2;
        if (tx !== e) begin errors++; $display("FAIL flow_tx[%0d]: got %b want %b", i, tx, e); end
        if (done !== (i == n - 1)) begin errors++; $display("FAIL flow_done[%0d]: got %b want %b", i, done, (i == n - 1)); end
        @(negedge clk);
      end
    end
    hw = 1'b0; cts_n = 1'b0;
  endtask

  task automatic test_abort();
    bit ok, bad;
    bitlen = 32'd4; mode = FULL_PERIOD;
    // Flush during DATA bit 3.
    push_byte(8'hF0);
    wait_started(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL abort_start: no tx_started_o within 300 clocks");
    end else begin
      repeat (17) @(negedge clk);
      checks++;
      if (tx !== exp_q[17]) begin errors++; $display("FAIL abort_bit3: got %b want %b", tx, exp_q[17]); end
      flush = 1'b1;
      #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL abort_done_now: got %b want 0", done); end
      @(negedge clk);
      flush = 1'b0;
      checks += 2;
      if (tx !== 1'b1)   begin errors++; $display("FAIL abort_tx: got %b want 1", tx); end
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
      bad = 1'b0;
      repeat (60) begin
        bad |= (done === 1'b1) || (busy === 1'b1) || (tx !== 1'b1);
        @(negedge clk);
      end
      checks++;
      if (bad) begin errors++; $display("FAIL abort_quiet: activity %b want 0 after flush", bad); end
    end
    exp_q.delete(); len_q.delete();
    // Flush held with data queued: no pop.
    flush = 1'b1;
    push_byte(8'h33);
    bad = 1'b0;
    repeat (5) begin
      #1;
      bad |= (fifo_rd === 1'b1) || (busy === 1'b1);
      @(negedge clk);
    end
    checks++;
    if (bad) begin errors++; $display("FAIL flush_rd: pop/busy %b want 0 while flushing", bad); end
    flush = 1'b0;
    // Reset asserted inside STOP.
    wait_started(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rst_start: no tx_started_o within 300 clocks");
    end else begin
      repeat (37) @(negedge clk);
      rstn = 1'b0;
      #1;
      checks += 3;
      if (tx !== 1'b1)   begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
    end
    exp_q.delete(); len_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok, e;
    int n1, n;
    bitlen = 32'd3; mode = TWO_PERIODS;
    push_byte(8'h3C);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    push_byte(8'hC3);
    wait_started(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_start: no tx_started_o within 300 clocks");
      exp_q.delete(); len_q.delete();
    end else begin
      n1 = len_q.pop_front();
      n  = n1 + 2 + len_q.pop_front();
      for (int i = 0; i < n; i++) begin
        e = exp_q.pop_front();
        checks += 3;
        if (tx !== e) begin errors++; $display("FAIL b2b_tx[%0d]: got %b want %b", i, tx, e); end
        if (done !== (i == n1 - 1 || i == n - 1)) begin errors++; $display("FAIL b2b_done[%0d]: got %b", i, done); end
        if (started !== (i == 0 || i == n1 + 2)) begin errors++; $display("FAIL b2b_started[%0d]: got %b", i, started); end
        @(negedge clk);
      end
    end
    mode = FULL_PERIOD;
  endtask

  task automatic test_clamp();
    bit ok, e;
    int n;
    bitlen = 32'd0; mode = FULL_PERIOD;
    push_byte(8'h81);
    wait_started(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL clamp_start: no tx_started_o within 300 clocks");
      exp_q.delete(); len_q.delete();
    end else begin
      n = len_q.pop_front();
      for (int i = 0; i < n; i++) begin
        e = exp_q.pop_front();
        checks += 2;
        if (tx !== e) begin errors++; $display("FAIL clamp_tx[%0d]: got %b want %b", i, tx, e); end
        if (done !== (i == n - 1)) begin errors++; $display("FAIL clamp_done[%0d]: got %b want %b", i, done, (i == n - 1)); end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; msb = 1'b0; par = 1'b0; hw = 1'b0; cts_n = 1'b0; flush = 1'b0;
    bitlen = 32'd4; mode = FULL_PERIOD;
    @(negedge clk);
    test_reset();
    test_lsb_frame();
    test_msb_parity();
    test_stop_sweep();
    test_flow_ctrl();
    test_abort();
    test_back_to_back();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
